// File: rtl/sap2_computer_if.sv
// Memory read bus between the SAP-2 CPU (master) and its ROM/RAM (slaves).
// Each memory returns its own registered read data; the CPU selects by address region.
interface sap2_computer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rom_rdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (output addr, input rom_rdata, input ram_rdata);
    modport slave  (input addr, output rom_rdata, output ram_rdata);
endinterface

// File: rtl/sap2_computer.sv
// SAP-2-style 8-bit computer: multi-cycle CPU, program ROM at ROM_BASE, data RAM at 0x0000.
// Optional ADD_B/ADD_C opcodes are enabled by defining SAP2_ADD_INSTR_EN.
module sap2_control_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] opcode_o,
    output logic                  pc_inc_o,
    output logic                  temp_ld_o,
    output logic                  commit_ldi_o,
    output logic                  commit_alu_o
);
    typedef enum logic [3:0] {
        S_RESET, S_INIT, S_F_ADDR, S_F_READ, S_F_DATA, S_CHK,
        S_O_ADDR, S_O_READ, S_O_DATA, S_EX1, S_EX2, S_EX3, S_HALT
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] opcode;
    logic                  is_ldi, is_alu, is_hlt;

    assign opcode_o = opcode;

    always_comb begin
        is_hlt = (opcode == 8'h01);
        is_ldi = (opcode == 8'h10) || (opcode == 8'h11) || (opcode == 8'h12);
        is_alu = (opcode == 8'h22) || (opcode == 8'h23);
`ifdef SAP2_ADD_INSTR_EN
        is_alu = is_alu || (opcode == 8'h20) || (opcode == 8'h21);
`else
        is_alu = is_alu;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            opcode  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_F_DATA) begin
                opcode <= rdata_i;
            end
        end
    end

    // Commits fire on the transition into F_ADDR so the latch overlaps the next fetch
    always_comb begin
        state_d      = state_q;
        pc_inc_o     = 1'b0;
        temp_ld_o    = 1'b0;
        commit_ldi_o = 1'b0;
        commit_alu_o = 1'b0;
        unique case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   state_d = S_F_ADDR;
            S_F_ADDR: state_d = S_F_READ;
            S_F_READ: state_d = S_F_DATA;
            S_F_DATA: begin
                state_d  = S_CHK;
                pc_inc_o = 1'b1;
            end
            S_CHK: begin
                if (is_hlt)      state_d = S_HALT;
                else if (is_ldi) state_d = S_O_ADDR;
                else if (is_alu) state_d = S_EX1;
                else             state_d = S_F_ADDR;
            end
            S_O_ADDR: state_d = S_O_READ;
            S_O_READ: state_d = S_O_DATA;
            S_O_DATA: begin
                state_d   = S_EX1;
                pc_inc_o  = 1'b1;
                temp_ld_o = 1'b1;
            end
            S_EX1: state_d = S_EX2;
            S_EX2: begin
                if (is_ldi) begin
                    state_d      = S_F_ADDR;
                    commit_ldi_o = 1'b1;
                end else begin
                    state_d = S_EX3;
                end
            end
            S_EX3: begin
                state_d      = S_F_ADDR;
                commit_alu_o = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end
endmodule

module sap2_cpu #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000
) (
    input  logic            clk,
    input  logic            reset,
    sap2_computer_if.master bus
);
    logic [ADDR_WIDTH-1:0] counter_out;
    logic [DATA_WIDTH-1:0] a_out, b_out, c_out, temp_1_out, opcode;
    logic                  flag_zero_o, flag_negative_o, flag_carry_o;
    logic [DATA_WIDTH-1:0] rdata, src;
    logic [DATA_WIDTH:0]   sum;
    logic                  pc_inc, temp_ld, commit_ldi, commit_alu;

    assign bus.addr = counter_out;
    assign rdata    = (counter_out >= ROM_BASE) ? bus.rom_rdata : bus.ram_rdata;

    sap2_control_unit #(.DATA_WIDTH(DATA_WIDTH)) u_control_unit (
        .clk          (clk),
        .reset        (reset),
        .rdata_i      (rdata),
        .opcode_o     (opcode),
        .pc_inc_o     (pc_inc),
        .temp_ld_o    (temp_ld),
        .commit_ldi_o (commit_ldi),
        .commit_alu_o (commit_alu)
    );

    // opcode[0] picks B/C as the addend; opcode[1] separates ADC from ADD
    always_comb begin
        src = opcode[0] ? c_out : b_out;
        sum = {1'b0, a_out} + {1'b0, src} + (DATA_WIDTH+1)'(opcode[1] & flag_carry_o);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_out     <= ROM_BASE;
            a_out           <= '0;
            b_out           <= '0;
            c_out           <= '0;
            temp_1_out      <= '0;
            flag_zero_o     <= 1'b0;
            flag_negative_o <= 1'b0;
            flag_carry_o    <= 1'b0;
        end else begin
            if (pc_inc) begin
                counter_out <= counter_out + ADDR_WIDTH'(1);
            end
            if (temp_ld) begin
                temp_1_out <= rdata;
            end
            if (commit_ldi) begin
                unique case (opcode[1:0])
                    2'd0:    a_out <= temp_1_out;
                    2'd1:    b_out <= temp_1_out;
                    default: c_out <= temp_1_out;
                endcase
                flag_zero_o     <= (temp_1_out == '0);
                flag_negative_o <= temp_1_out[DATA_WIDTH-1];
            end
            if (commit_alu) begin
                a_out           <= sum[DATA_WIDTH-1:0];
                flag_carry_o    <= sum[DATA_WIDTH];
                flag_zero_o     <= (sum[DATA_WIDTH-1:0] == '0);
                flag_negative_o <= sum[DATA_WIDTH-1];
            end
        end
    end
endmodule

module sap2_rom #(
    parameter int DATA_WIDTH = 8,
    parameter int ROM_DEPTH  = 256
) (
    input  logic           clk,
    sap2_computer_if.slave bus
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [ROM_DEPTH];

    always_ff @(posedge clk) begin
        bus.rom_rdata <= mem[bus.addr[AW-1:0]];
    end

    task automatic init_sim_rom();
        for (int i = 0; i < ROM_DEPTH; i++) mem[i] = '0;
    endtask

    // Image checksum: lets a bench confirm what was loaded without printing it
    function automatic logic [15:0] dump();
        logic [15:0] acc = '0;
        for (int i = 0; i < ROM_DEPTH; i++) acc = acc + 16'(mem[i]);
        return acc;
    endfunction
endmodule

module sap2_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic           clk,
    sap2_computer_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        bus.ram_rdata <= mem[bus.addr[AW-1:0]];
    end

    task automatic init_sim_ram();
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    endtask
endmodule

module sap2_computer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000,
    parameter int                    ROM_DEPTH  = 256,
    parameter int                    RAM_DEPTH  = 256
) (
    input logic clk,
    input logic reset
);
    sap2_computer_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bus ();

    sap2_cpu #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ROM_BASE(ROM_BASE)) u_cpu (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus.master)
    );

    sap2_rom #(.DATA_WIDTH(DATA_WIDTH), .ROM_DEPTH(ROM_DEPTH)) u_rom (
        .clk (clk),
        .bus (u_bus.slave)
    );

    sap2_ram #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_ram (
        .clk (clk),
        .bus (u_bus.slave)
    );
endmodule

// File: tb/tb_sap2_computer.sv
// Directed bench for sap2_computer: loads ROM programs and checks internal state at fixed edge counts.
module tb_sap2_computer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sap2_computer dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input logic [7:0] prog [9]);
        dut.u_rom.init_sim_rom();
        for (int i = 0; i < 9; i++) dut.u_rom.mem[i] = prog[i];
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [2:0] znc);
        chk({tag, "_A"}, {8'h00, dut.u_cpu.a_out}, {8'h00, a});
        chk({tag, "_B"}, {8'h00, dut.u_cpu.b_out}, {8'h00, b});
        chk({tag, "_C"}, {8'h00, dut.u_cpu.c_out}, {8'h00, c});
        chk({tag, "_ZNC"}, {13'h0, dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                            dut.u_cpu.flag_carry_o}, {13'h0, znc});
    endtask

    logic [7:0] prog_main [9];
    logic [7:0] prog_add  [9];

    initial begin
        prog_main = '{8'h10, 8'hFF, 8'h11, 8'h01, 8'h12, 8'h05, 8'h22, 8'h23, 8'h01};
        prog_add  = '{8'h10, 8'h07, 8'h11, 8'hFF, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00};
        load_rom(prog_main);
        dut.u_ram.init_sim_ram();

        // Reset state
        step(2);
        chk("rst_pc", dut.u_cpu.counter_out, 16'hF000);
        chk("rst_temp", {8'h00, dut.u_cpu.temp_1_out}, 16'h0000);
        chk("rst_op", {8'h00, dut.u_cpu.opcode}, 16'h0000);
        chk_regs("rst", 8'h00, 8'h00, 8'h00, 3'b000);
        chk("rom_sum", dut.u_rom.dump(), 16'h017E);

        // Main program, edges counted from release
        reset = 1'b1;
        step(5);
        chk("op_ldia", {8'h00, dut.u_cpu.opcode}, 16'h0010);
        chk("pc_after_fetch", dut.u_cpu.counter_out, 16'hF001);
        step(4);
        chk("temp_ff", {8'h00, dut.u_cpu.temp_1_out}, 16'h00FF);
        chk("pc_after_opnd", dut.u_cpu.counter_out, 16'hF002);
        step(2);
        chk_regs("ldia", 8'hFF, 8'h00, 8'h00, 3'b010);
        step(3);
        chk("op_ldib", {8'h00, dut.u_cpu.opcode}, 16'h0011);
        step(4);
        chk("temp_01", {8'h00, dut.u_cpu.temp_1_out}, 16'h0001);
        step(2);
        chk_regs("ldib", 8'hFF, 8'h01, 8'h00, 3'b000);
        step(3);
        chk("op_ldic", {8'h00, dut.u_cpu.opcode}, 16'h0012);
        step(6);
        chk_regs("ldic", 8'hFF, 8'h01, 8'h05, 3'b000);
        step(3);
        chk("op_adcb", {8'h00, dut.u_cpu.opcode}, 16'h0022);
        step(4);
        chk_regs("adcb", 8'h00, 8'h01, 8'h05, 3'b101);
        step(3);
        chk("op_adcc", {8'h00, dut.u_cpu.opcode}, 16'h0023);
        step(4);
        chk_regs("adcc", 8'h06, 8'h01, 8'h05, 3'b000);
        step(3);
        chk("op_hlt", {8'h00, dut.u_cpu.u_control_unit.opcode}, 16'h0001);
        chk("pc_hlt", dut.u_cpu.counter_out, 16'hF009);
        step(20);
        chk("pc_halted", dut.u_cpu.counter_out, 16'hF009);
        chk_regs("halted", 8'h06, 8'h01, 8'h05, 3'b000);

        // Rerun, then abort with a one-edge reset in the middle of ADC_B
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(32);
        chk("op_adcb_2", {8'h00, dut.u_cpu.opcode}, 16'h0022);
        step(2);
        reset = 1'b0;
        step(1);
        chk("abort_pc", dut.u_cpu.counter_out, 16'hF000);
        chk("abort_op", {8'h00, dut.u_cpu.u_control_unit.opcode}, 16'h0000);
        chk_regs("abort", 8'h00, 8'h00, 8'h00, 3'b000);
        reset = 1'b1;
        step(5);
        chk("rerun_op", {8'h00, dut.u_cpu.opcode}, 16'h0010);
        step(6);
        chk_regs("rerun_ldia", 8'hFF, 8'h00, 8'h00, 3'b010);
        step(25);
        chk_regs("rerun_adcb", 8'h00, 8'h01, 8'h05, 3'b101);
        step(10);
        chk("rerun_hlt", {8'h00, dut.u_cpu.u_control_unit.opcode}, 16'h0001);
        chk("rerun_pc", dut.u_cpu.counter_out, 16'hF009);

        // Opcode 0x20 with A=07, B=FF
        reset = 1'b0;
        load_rom(prog_add);
        step(1);
        reset = 1'b1;
        step(20);
        chk_regs("add_pre", 8'h07, 8'hFF, 8'h00, 3'b010);
        step(3);
        chk("op_add", {8'h00, dut.u_cpu.opcode}, 16'h0020);
`ifdef SAP2_ADD_INSTR_EN
        step(4);
        chk_regs("add_b", 8'h06, 8'hFF, 8'h00, 3'b001);
        step(3);
        chk("add_hlt", {8'h00, dut.u_cpu.opcode}, 16'h0001);
        chk_regs("add_hlt", 8'h06, 8'hFF, 8'h00, 3'b001);
`else
        step(1);
        step(3);
        chk("add_nop_hlt", {8'h00, dut.u_cpu.opcode}, 16'h0001);
        chk_regs("add_nop", 8'h07, 8'hFF, 8'h00, 3'b010);
`endif
        chk("add_pc", dut.u_cpu.counter_out, 16'hF006);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
